// File: rtl/pass_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pass_pkg
//  Brief    : Shared arbitration-mode encodings for the pass_rr_mux family.
//  Revision : 1.0  initial release
// ============================================================================
package pass_pkg;

    localparam int c_ARB_RR   = 0;
    localparam int c_ARB_PRIO = 1;

endpackage
`default_nettype wire

// File: rtl/pass_ch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pass_ch_fifo
//  Brief    : Per-channel FIFO; a push into a full FIFO is only taken when a
//             pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module pass_ch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_full;

    logic             w_do_push;
    logic             w_do_pop;
    logic [c_AW:0]    w_count_nxt;

    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = i_push & (!r_full | w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + (c_AW + 1)'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - (c_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;

endmodule
`default_nettype wire

// File: rtl/pass_rr_mux.sv
`default_nettype none
// ============================================================================
//  Module   : pass_rr_mux
//  Brief    : Multi-channel buffered mux with round-robin or fixed-priority
//             arbitration into a single registered output stage.
//  Revision : 1.0  initial release
// ============================================================================
module pass_rr_mux
    import pass_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CH       = 3,
    parameter int ARB_MODE = c_ARB_RR
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [CH-1:0]           i_WrEn,
    input  logic [CH*WIDTH-1:0]     i_WrData,
    input  logic                    i_Ready,
    output logic                    o_Valid,
    output logic [WIDTH-1:0]        o_Data,
    output logic [$clog2(CH)-1:0]   o_Ch,
    output logic [CH-1:0]           o_Full,
    output logic [CH-1:0]           o_Overflow
);

    localparam int              c_CW   = $clog2(CH);
    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_CW:0]   c_CH_W = (c_CW + 1)'(CH);

    logic [CH-1:0]    w_empty;
    logic [CH-1:0]    w_full;
    logic [CH-1:0]    w_req;
    logic [CH-1:0]    w_gnt;
    logic [CH-1:0]    w_pop;
    logic [CH-1:0]    w_push;
    logic [CH-1:0]    w_drop;
    logic [WIDTH-1:0] w_head  [CH];
    logic [WIDTH-1:0] w_wdata [CH];
    logic [c_AW:0]    w_count [CH];

    logic             w_adv;
    logic             w_gnt_vld;
    logic [c_CW-1:0]  w_gnt_idx;
    logic [c_CW:0]    w_rr_sum;
    logic [c_CW-1:0]  w_rr_k;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [c_CW-1:0]  r_ch;
    logic [CH-1:0]    r_ovf;
    logic [c_CW-1:0]  r_rr_start;

    assign w_adv = !r_valid | i_Ready;

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            assign w_wdata[c] = i_WrData[c*WIDTH +: WIDTH];
            assign w_empty[c] = (w_count[c] == '0);
            assign w_req[c]   = !w_empty[c] | i_WrEn[c];
            assign w_gnt[c]   = w_adv & w_gnt_vld & (w_gnt_idx == c_CW'(c));
            assign w_pop[c]   = w_gnt[c] & !w_empty[c];
            // A granted channel with nothing queued sends its write straight out.
            assign w_push[c]  = i_WrEn[c] & !(w_gnt[c] & w_empty[c]);
            assign w_drop[c]  = w_push[c] & w_full[c] & !w_pop[c];

            pass_ch_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (CLK),
                .rst     (Reset),
                .i_push  (w_push[c]),
                .i_pop   (w_pop[c]),
                .i_data  (w_wdata[c]),
                .o_head  (w_head[c]),
                .o_count (w_count[c]),
                .o_full  (w_full[c])
            );
        end
    endgenerate

    // Scan from the highest search offset down so the earliest candidate wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_rr_sum  = '0;
        w_rr_k    = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (ARB_MODE == c_ARB_PRIO) begin
                w_rr_sum = (c_CW + 1)'(i);
            end else begin
                w_rr_sum = {1'b0, r_rr_start} + (c_CW + 1)'(i);
            end
            if (w_rr_sum >= c_CH_W) begin
                w_rr_sum = w_rr_sum - c_CH_W;
            end
            w_rr_k = w_rr_sum[c_CW-1:0];
            if (w_req[w_rr_k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_rr_k;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_ch       <= '0;
            r_ovf      <= '0;
            r_rr_start <= '0;
        end else begin
            r_ovf <= r_ovf | w_drop;
            if (w_adv) begin
                r_valid <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_data <= w_empty[w_gnt_idx] ? w_wdata[w_gnt_idx] : w_head[w_gnt_idx];
                    r_ch   <= w_gnt_idx;
                    if (ARB_MODE == c_ARB_RR) begin
                        r_rr_start <= (w_gnt_idx == c_CW'(CH - 1)) ? '0 : w_gnt_idx + c_CW'(1);
                    end
                end
            end
        end
    end

    assign o_Valid    = r_valid;
    assign o_Data     = r_data;
    assign o_Ch       = r_ch;
    assign o_Full     = w_full;
    assign o_Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pass_rr_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pass_rr_mux
//  Brief    : Directed bench for pass_rr_mux (round-robin and priority builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pass_rr_mux;
    import pass_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CH    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     wr_en = '0;
    logic [CH*WIDTH-1:0] wr_data = '0;
    logic              ready = 1'b1;
    logic              o_valid;
    logic [WIDTH-1:0]  o_data;
    logic [1:0]        o_ch;
    logic [CH-1:0]     o_full;
    logic [CH-1:0]     o_ovf;

    logic [CH-1:0]     p_wr_en = '0;
    logic [CH*WIDTH-1:0] p_wr_data = '0;
    logic              p_valid;
    logic [WIDTH-1:0]  p_data;
    logic [1:0]        p_ch;
    logic [CH-1:0]     p_full;
    logic [CH-1:0]     p_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pass_rr_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH(CH), .ARB_MODE(c_ARB_RR)) dut (
        .CLK(clk), .Reset(rst), .i_WrEn(wr_en), .i_WrData(wr_data), .i_Ready(ready),
        .o_Valid(o_valid), .o_Data(o_data), .o_Ch(o_ch), .o_Full(o_full), .o_Overflow(o_ovf)
    );

    pass_rr_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH(CH), .ARB_MODE(c_ARB_PRIO)) dut_p (
        .CLK(clk), .Reset(rst), .i_WrEn(p_wr_en), .i_WrData(p_wr_data), .i_Ready(1'b1),
        .o_Valid(p_valid), .o_Data(p_data), .o_Ch(p_ch), .o_Full(p_full), .o_Overflow(p_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = '0; p_wr_en = '0; ready = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({o_valid, o_ch, o_data, o_full, o_ovf} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b ch=%0d d=%h full=%b ovf=%b, want all zero",
                     o_valid, o_ch, o_data, o_full, o_ovf);
        end
    endtask

    task automatic test_bypass();
        for (int v = 1; v <= 4; v++) begin
            wr_en = 3'b001; wr_data = {16'h0, 8'(v)};
            step();
            n_cmp++;
            if ({o_valid, o_ch, o_data, o_full} !== {1'b1, 2'd0, 8'(v), 3'b000}) begin
                n_fail++;
                $display("FAIL bypass_%0d: got v=%0b ch=%0d d=%h full=%b, want v=1 ch=0 d=%h full=000",
                         v, o_valid, o_ch, o_data, o_full, v);
            end
        end
        wr_en = '0;
        step();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_idle: got v=%0b, want 0", o_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        for (int v = 5; v <= 10; v++) begin
            wr_en = 3'b010; wr_data = {8'h0, 8'(v), 8'h0};
            step();
            n_cmp++;
            if ({o_valid, o_ch, o_data} !== {1'b1, 2'd1, 8'h05}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got v=%0b ch=%0d d=%h, want v=1 ch=1 d=05",
                         v, o_valid, o_ch, o_data);
            end
            if (v == 9) begin
                n_cmp++;
                if ({o_full, o_ovf} !== {3'b010, 3'b000}) begin
                    n_fail++;
                    $display("FAIL bp_full: got full=%b ovf=%b, want full=010 ovf=000", o_full, o_ovf);
                end
            end
        end
        n_cmp++;
        if ({o_full, o_ovf} !== {3'b010, 3'b010}) begin
            n_fail++;
            $display("FAIL bp_overflow: got full=%b ovf=%b, want full=010 ovf=010", o_full, o_ovf);
        end
        wr_en = '0; ready = 1'b1;
        for (int v = 6; v <= 9; v++) begin
            step();
            n_cmp++;
            if ({o_valid, o_ch, o_data, o_ovf} !== {1'b1, 2'd1, 8'(v), 3'b010}) begin
                n_fail++;
                $display("FAIL bp_drain_%0d: got v=%0b ch=%0d d=%h ovf=%b, want v=1 ch=1 d=%h ovf=010",
                         v, o_valid, o_ch, o_data, o_ovf, v);
            end
            if (v == 6) begin
                n_cmp++;
                if (o_full !== 3'b000) begin
                    n_fail++;
                    $display("FAIL bp_unfull: got full=%b, want 000", o_full);
                end
            end
        end
        step();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: got v=%0b, want 0 (dropped word must not appear)", o_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [6];
        logic [1:0] exp_c [6];
        exp_d = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        do_reset();
        for (int b = 0; b < 2; b++) begin
            wr_en = 3'b111;
            wr_data = (b == 0) ? {8'h30, 8'h20, 8'h10} : {8'h31, 8'h21, 8'h11};
            for (int k = 0; k < 3; k++) begin
                step();
                wr_en = '0;
                n_cmp++;
                if ({o_valid, o_ch, o_data} !== {1'b1, exp_c[b*3+k], exp_d[b*3+k]}) begin
                    n_fail++;
                    $display("FAIL rr_%0d: got v=%0b ch=%0d d=%h, want v=1 ch=%0d d=%h",
                             b*3+k, o_valid, o_ch, o_data, exp_c[b*3+k], exp_d[b*3+k]);
                end
            end
            step();
            n_cmp++;
            if (o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap_%0d: got v=%0b, want 0", b, o_valid);
            end
        end
        // ch0 served last, so ch1 must win a ch0/ch1 tie next.
        wr_en = 3'b001; wr_data = {16'h0, 8'h40};
        step();
        wr_en = 3'b011; wr_data = {8'h0, 8'h50, 8'h41};
        step();
        n_cmp++;
        if ({o_valid, o_ch, o_data} !== {1'b1, 2'd1, 8'h50}) begin
            n_fail++;
            $display("FAIL rr_fair: got v=%0b ch=%0d d=%h, want v=1 ch=1 d=50", o_valid, o_ch, o_data);
        end
        wr_en = '0;
        step();
        n_cmp++;
        if ({o_valid, o_ch, o_data} !== {1'b1, 2'd0, 8'h41}) begin
            n_fail++;
            $display("FAIL rr_fair_next: got v=%0b ch=%0d d=%h, want v=1 ch=0 d=41", o_valid, o_ch, o_data);
        end
    endtask

    task automatic test_prio();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            p_wr_en = 3'b101; p_wr_data = {8'(8'hC0 + i), 8'h00, 8'(8'h80 + i)};
            step();
            n_cmp++;
            if ({p_valid, p_ch, p_data} !== {1'b1, 2'd0, 8'(8'h80 + i)}) begin
                n_fail++;
                $display("FAIL prio_%0d: got v=%0b ch=%0d d=%h, want v=1 ch=0 d=%h",
                         i, p_valid, p_ch, p_data, 8'h80 + i);
            end
        end
        p_wr_en = '0;
        n_cmp++;
        if ({p_full, p_ovf} !== {3'b100, 3'b100}) begin
            n_fail++;
            $display("FAIL prio_flags: got full=%b ovf=%b, want full=100 ovf=100", p_full, p_ovf);
        end
        for (int j = 0; j < 4; j++) begin
            step();
            n_cmp++;
            if ({p_valid, p_ch, p_data} !== {1'b1, 2'd2, 8'(8'hC0 + j)}) begin
                n_fail++;
                $display("FAIL prio_drain_%0d: got v=%0b ch=%0d d=%h, want v=1 ch=2 d=%h",
                         j, p_valid, p_ch, p_data, 8'hC0 + j);
            end
        end
    endtask

    task automatic test_empty_boundary();
        do_reset();
        ready = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            wr_en = 3'b010; wr_data = {8'h0, 8'(v), 8'h0};
            step();
        end
        wr_en = '0; ready = 1'b1;
        step();
        n_cmp++;
        if ({o_valid, o_ch, o_data} !== {1'b1, 2'd1, 8'h02}) begin
            n_fail++;
            $display("FAIL eb_first: got v=%0b ch=%0d d=%h, want v=1 ch=1 d=02", o_valid, o_ch, o_data);
        end
        wr_en = 3'b010; wr_data = {8'h0, 8'h55, 8'h0};
        step();
        wr_en = '0;
        n_cmp++;
        if ({o_valid, o_ch, o_data} !== {1'b1, 2'd1, 8'h03}) begin
            n_fail++;
            $display("FAIL eb_last: got v=%0b ch=%0d d=%h, want v=1 ch=1 d=03", o_valid, o_ch, o_data);
        end
        step();
        n_cmp++;
        if ({o_valid, o_ch, o_data} !== {1'b1, 2'd1, 8'h55}) begin
            n_fail++;
            $display("FAIL eb_nogap: got v=%0b ch=%0d d=%h, want v=1 ch=1 d=55", o_valid, o_ch, o_data);
        end
        step();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL eb_end: got v=%0b, want 0", o_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b0;
        wr_en = 3'b111; wr_data = {8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if ({o_full, o_ovf} !== {3'b111, 3'b111}) begin
            n_fail++;
            $display("FAIL rm_loaded: got full=%b ovf=%b, want full=111 ovf=111", o_full, o_ovf);
        end
        rst = 1'b1; wr_en = '0; ready = 1'b1;
        step();
        n_cmp++;
        if ({o_valid, o_full, o_ovf} !== 7'd0) begin
            n_fail++;
            $display("FAIL rm_cleared: got v=%0b full=%b ovf=%b, want all zero", o_valid, o_full, o_ovf);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_no_stale: got v=%0b d=%h, want v=0", o_valid, o_data);
        end
        wr_en = 3'b100; wr_data = {8'h77, 16'h0};
        step();
        wr_en = '0;
        n_cmp++;
        if ({o_valid, o_ch, o_data} !== {1'b1, 2'd2, 8'h77}) begin
            n_fail++;
            $display("FAIL rm_bypass: got v=%0b ch=%0d d=%h, want v=1 ch=2 d=77", o_valid, o_ch, o_data);
        end
        step();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_end: got v=%0b, want 0", o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_backpressure();
        test_round_robin();
        test_prio();
        test_empty_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
